// File: rtl/mmio_reg_bank.sv
// MMIO register bank: ID, scratch, control, free-running timer with compare, W1C interrupt status.
// Define MMIO_PERF_CNT_EN to add the read-only accepted-request counter at offset 0x18.

package const_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
endpackage

module mmio_reg_bank #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'hE3B0_0001
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output const_pkg::resp_t    rsp_resp,
  output logic                irq
);

  localparam logic [2:0] IDX_ID      = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_CTRL    = 3'd2;
  localparam logic [2:0] IDX_TIMER   = 3'd3;
  localparam logic [2:0] IDX_COMPARE = 3'd4;
  localparam logic [2:0] IDX_STATUS  = 3'd5;
  localparam logic [2:0] IDX_REQCNT  = 3'd6;

  logic [31:0]      scratch;
  logic [1:0]       ctrl;
  logic [31:0]      timer;
  logic [31:0]      compare;
  logic             match;

  logic             accept;
  logic [2:0]       idx;
  logic             in_window;
  logic             mapped;
  logic             read_only;
  logic [31:0]      reg_rdata;
  const_pkg::resp_t dec_resp;
  logic [31:0]      dec_rdata;
  logic             wr_en;
  logic             timer_wr;
  logic             match_set;
  logic             match_clr;

`ifdef MMIO_PERF_CNT_EN
  logic [31:0]      req_cnt;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // The slot frees up on the same edge the held response is taken, allowing back-to-back traffic.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[4:2];
  assign in_window = ((req_addr >> 5) == '0);

  always_comb begin
    mapped    = 1'b0;
    read_only = 1'b0;
    reg_rdata = '0;
    case (idx)
      IDX_ID:      begin mapped = 1'b1; read_only = 1'b1; reg_rdata = ID_VALUE; end
      IDX_SCRATCH: begin mapped = 1'b1; reg_rdata = scratch; end
      IDX_CTRL:    begin mapped = 1'b1; reg_rdata = {30'd0, ctrl}; end
      IDX_TIMER:   begin mapped = 1'b1; reg_rdata = timer; end
      IDX_COMPARE: begin mapped = 1'b1; reg_rdata = compare; end
      IDX_STATUS:  begin mapped = 1'b1; reg_rdata = {31'd0, match}; end
`ifdef MMIO_PERF_CNT_EN
      IDX_REQCNT:  begin mapped = 1'b1; read_only = 1'b1; reg_rdata = req_cnt; end
`endif
      default:     begin mapped = 1'b0; end
    endcase
  end

  always_comb begin
    dec_resp  = const_pkg::OKAY;
    dec_rdata = '0;
    if (req_addr[1:0] != 2'b00) begin
      dec_resp = const_pkg::SLVERR;
    end else if (!in_window || !mapped) begin
      dec_resp = const_pkg::DECERR;
    end else if (req_write && read_only) begin
      dec_resp = const_pkg::SLVERR;
    end else if (!req_write) begin
      dec_rdata = reg_rdata;
    end
  end

  assign wr_en     = accept && req_write && (dec_resp == const_pkg::OKAY);
  assign timer_wr  = wr_en && (idx == IDX_TIMER) && (req_wstrb != 4'd0);
  assign match_set = ctrl[0] && (timer == compare);
  assign match_clr = wr_en && (idx == IDX_STATUS) && req_wstrb[0] && req_wdata[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= const_pkg::OKAY;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= dec_rdata;
      rsp_resp  <= dec_resp;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      ctrl    <= '0;
      compare <= '0;
    end else if (wr_en) begin
      if (idx == IDX_SCRATCH) scratch <= merge_bytes(scratch, req_wdata, req_wstrb);
      if (idx == IDX_COMPARE) compare <= merge_bytes(compare, req_wdata, req_wstrb);
      if (idx == IDX_CTRL && req_wstrb[0]) ctrl <= req_wdata[1:0];
    end
  end

  // A software write to TIMER overrides the increment for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (timer_wr) begin
      timer <= merge_bytes(timer, req_wdata, req_wstrb);
    end else if (ctrl[0]) begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
      irq   <= 1'b0;
    end else begin
      match <= match_set || (match && !match_clr);
      irq   <= ctrl[1] && match;
    end
  end

`ifdef MMIO_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt <= '0;
    end else if (accept) begin
      req_cnt <= req_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_reg_bank.sv
// Scoreboard bench for mmio_reg_bank: a driver queues expected responses, a monitor retires them.
// Honours MMIO_PERF_CNT_EN to select the expected behaviour at offset 0x18.

module tb_mmio_reg_bank;
  import const_pkg::*;

  localparam logic [31:0] ID = 32'hE3B0_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  resp_t       rsp_resp;
  logic        irq;

  int tests = 0;
  int failures = 0;
  int issued = 0;

  typedef struct {
    logic [31:0] rdata;
    resp_t       resp;
    int          id;
  } exp_t;

  exp_t sb[$];

  mmio_reg_bank #(.ADDR_W(8), .ID_VALUE(ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge where the request was taken.
  task automatic apply_stimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                                input logic [3:0] st, input logic [31:0] exp_rd,
                                input resp_t exp_rsp, output int waited);
    exp_t e;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = st;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!req_ready) begin
      tests++;
      failures++;
      $display("[TB] FAIL accept_timeout addr %h: got req_ready=0 expected 1", addr);
    end else begin
      e.rdata = exp_rd;
      e.resp  = exp_rsp;
      e.id    = issued;
      issued++;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_rsp: got rdata %h resp %0d expected no response",
                 rsp_rdata, rsp_resp);
      end else begin
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
          failures++;
          $display("[TB] FAIL rsp%0d: got rdata %h resp %0d expected rdata %h resp %0d",
                   e.id, rsp_rdata, rsp_resp, e.rdata, e.resp);
        end
      end
    end
  end

  initial begin
    int w;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_req_ready", req_ready, 1);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_rsp_rdata", rsp_rdata, 0);
    check_output("reset_rsp_resp", rsp_resp, OKAY);
    check_output("reset_irq", irq, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(0, 8'h00, 0, 4'h0, ID, OKAY, w);
    check_output("read_latency", rsp_valid, 1);
    apply_stimulus(0, 8'h24, 0, 4'h0, 0, DECERR, w);

    apply_stimulus(1, 8'h04, 32'hAABB_CCDD, 4'b0101, 0, OKAY, w);
    apply_stimulus(0, 8'h04, 0, 4'h0, 32'h00BB_00DD, OKAY, w);
    apply_stimulus(1, 8'h04, 32'hFFFF_FFFF, 4'b0000, 0, OKAY, w);
    apply_stimulus(0, 8'h04, 0, 4'h0, 32'h00BB_00DD, OKAY, w);
    apply_stimulus(1, 8'h00, 32'h1234_5678, 4'hF, 0, SLVERR, w);
    apply_stimulus(0, 8'h00, 0, 4'h0, ID, OKAY, w);
    apply_stimulus(0, 8'h06, 0, 4'h0, 0, SLVERR, w);
    apply_stimulus(1, 8'h06, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, w);

    // Back-pressure: let the last response drain, then stall the next one.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    apply_stimulus(0, 8'h04, 0, 4'h0, 32'h00BB_00DD, OKAY, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_req_ready", req_ready, 0);
      check_output("stall_rsp_valid", rsp_valid, 1);
      check_output("stall_rsp_rdata", rsp_rdata, 32'h00BB_00DD);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    apply_stimulus(0, 8'h08, 0, 4'h0, 0, OKAY, w);
    check_output("same_edge_accept_wait", w, 0);

    // Timer counts 0..5 after enabling, match sets on the pre-increment 5, irq a cycle later.
    apply_stimulus(1, 8'h10, 32'd5, 4'hF, 0, OKAY, w);
    apply_stimulus(1, 8'h0C, 32'd0, 4'hF, 0, OKAY, w);
    apply_stimulus(1, 8'h08, 32'hFFFF_FFFF, 4'hF, 0, OKAY, w);
    cnt = 0;
    @(negedge clk);
    while (!irq && cnt < 12) begin
      cnt++;
      @(negedge clk);
    end
    check_output("irq_latency_cycles", cnt, 7);
    @(posedge clk);
    #1;
    apply_stimulus(0, 8'h08, 0, 4'h0, 32'd3, OKAY, w);
    apply_stimulus(0, 8'h14, 0, 4'h0, 32'd1, OKAY, w);

    apply_stimulus(1, 8'h14, 32'd1, 4'b0001, 0, OKAY, w);
    repeat (2) @(negedge clk);
    check_output("irq_after_w1c", irq, 0);
    @(posedge clk);
    #1;
    apply_stimulus(0, 8'h14, 0, 4'h0, 32'd0, OKAY, w);

    // Written value wins over the increment, then counts up and wraps.
    apply_stimulus(1, 8'h0C, 32'hFFFF_FFFE, 4'hF, 0, OKAY, w);
    apply_stimulus(0, 8'h0C, 0, 4'h0, 32'hFFFF_FFFE, OKAY, w);
    apply_stimulus(0, 8'h0C, 0, 4'h0, 32'hFFFF_FFFF, OKAY, w);
    apply_stimulus(0, 8'h0C, 0, 4'h0, 32'h0000_0000, OKAY, w);

    // TIMER=100 then COMPARE=103: the match fires on exactly the edge of the W1C write.
    apply_stimulus(1, 8'h0C, 32'd100, 4'hF, 0, OKAY, w);
    apply_stimulus(1, 8'h10, 32'd103, 4'hF, 0, OKAY, w);
    apply_stimulus(0, 8'h04, 0, 4'h0, 32'h00BB_00DD, OKAY, w);
    apply_stimulus(0, 8'h04, 0, 4'h0, 32'h00BB_00DD, OKAY, w);
    apply_stimulus(1, 8'h14, 32'd1, 4'b0001, 0, OKAY, w);
    apply_stimulus(0, 8'h14, 0, 4'h0, 32'd1, OKAY, w);

    // Reset while a response is held: it must vanish immediately.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    apply_stimulus(0, 8'h04, 0, 4'h0, 32'h00BB_00DD, OKAY, w);
    rst_n = 1'b0;
    #1;
    check_output("midreset_rsp_valid", rsp_valid, 0);
    check_output("midreset_req_ready", req_ready, 1);
    check_output("midreset_irq", irq, 0);
    sb.delete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(0, 8'h04, 0, 4'h0, 32'd0, OKAY, w);
`ifdef MMIO_PERF_CNT_EN
    apply_stimulus(0, 8'h24, 0, 4'h0, 0, DECERR, w);
    apply_stimulus(1, 8'h04, 32'h1, 4'hF, 0, OKAY, w);
    apply_stimulus(0, 8'h18, 0, 4'h0, 32'd3, OKAY, w);
    apply_stimulus(1, 8'h18, 32'h0, 4'hF, 0, SLVERR, w);
`else
    apply_stimulus(0, 8'h18, 0, 4'h0, 0, DECERR, w);
    apply_stimulus(1, 8'h18, 32'h0, 4'hF, 0, DECERR, w);
`endif

    cnt = 0;
    while (sb.size() != 0 && cnt < 20) begin
      cnt++;
      @(posedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending responses expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
